// File: rtl/pwm_pkg.sv
// Shared definitions for the SPI command decoder and the PWM register bank it feeds.
package pwm_pkg;

    localparam logic [7:0] ADDR_DUTY   = 8'h00;
    localparam logic [7:0] ADDR_PERIOD = 8'h01;
    localparam logic [7:0] ADDR_CTRL   = 8'h02;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_POL = 1;

    localparam logic [7:0] DEF_CHK_SEED = 8'h5A;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DATA = 2'd1,
        S_CHK  = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic [7:0] duty;
        logic [7:0] period;
        logic       en;
        logic       pol;
    } pwm_regs_t;

    // Checksum byte expected at the end of a frame.
    function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                             input logic [7:0] data,
                                             input logic [7:0] seed);
        return addr ^ data ^ seed;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream input and PWM control outputs of the SPI command decoder.
interface spi_cmd_decoder_if;

    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] duty;
    logic [7:0] period;
    logic       pwm_en;
    logic       pwm_pol;
    logic       update;
    logic       frame_err;
    logic [7:0] err_cnt;

    modport master (
        output cs_n, rx_data, rx_valid,
        input  duty, period, pwm_en, pwm_pol, update, frame_err, err_cnt
    );

    modport slave (
        input  cs_n, rx_data, rx_valid,
        output duty, period, pwm_en, pwm_pol, update, frame_err, err_cnt
    );

endinterface

// File: rtl/frame_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT_CYC and flags expiry while it holds that value.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (cnt_q != TW'(TIMEOUT_CYC)) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign expired_c = (cnt_q == TW'(TIMEOUT_CYC));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Assembles ADDR/DATA/CHK frames from the SPI byte stream and writes the PWM control registers.
module spi_cmd_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter logic [7:0]  CHK_SEED    = DEF_CHK_SEED,
    parameter logic [7:0]  PERIOD_RST  = 8'hFF
) (
    input logic              clk,
    input logic              rst_n,
    spi_cmd_decoder_if.slave bus
);

    localparam pwm_regs_t REGS_RST = '{duty: 8'h00, period: PERIOD_RST, en: 1'b0, pol: 1'b0};

    frame_state_e state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    pwm_regs_t    regs_q, regs_d;
    logic         update_q, update_d;
    logic         ferr_q, ferr_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    logic         timer_clear_c;
    logic         timer_expired_c;
    logic         abort_c;
    logic         reject_c;

    // Idle time only matters mid-frame, so the timer is held at zero while waiting for ADDR.
    assign timer_clear_c = bus.rx_valid || (state_q == S_ADDR);

    frame_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear_c),
        .expired_c(timer_expired_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ADDR;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            regs_q    <= REGS_RST;
            update_q  <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            regs_q    <= regs_d;
            update_q  <= update_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // A byte in the same cycle always wins over an abort; the abort can only act on a later cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        regs_d    = regs_q;
        update_d  = 1'b0;
        reject_c  = 1'b0;
        abort_c   = (bus.cs_n || timer_expired_c) && !bus.rx_valid;

        case (state_q)
            S_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d  = bus.rx_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    data_d  = bus.rx_data;
                    state_d = S_CHK;
                end else if (abort_c) begin
                    reject_c = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_CHK: begin
                if (bus.rx_valid) begin
                    state_d = S_ADDR;
                    if (bus.rx_data == frame_chk(addr_q, data_q, CHK_SEED)) begin
                        case (addr_q)
                            ADDR_DUTY: begin
                                regs_d.duty = data_q;
                                update_d    = 1'b1;
                            end
                            ADDR_PERIOD: begin
                                regs_d.period = data_q;
                                update_d      = 1'b1;
                            end
                            ADDR_CTRL: begin
                                regs_d.en  = data_q[CTRL_EN];
                                regs_d.pol = data_q[CTRL_POL];
                                update_d   = 1'b1;
                            end
                            default: reject_c = 1'b1;
                        endcase
                    end else begin
                        reject_c = 1'b1;
                    end
                end else if (abort_c) begin
                    reject_c = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            default: state_d = S_ADDR;
        endcase

        ferr_d    = reject_c;
        err_cnt_d = (reject_c && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign bus.duty      = regs_q.duty;
    assign bus.period    = regs_q.period;
    assign bus.pwm_en    = regs_q.en;
    assign bus.pwm_pol   = regs_q.pol;
    assign bus.update    = update_q;
    assign bus.frame_err = ferr_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: frame table, corner-case sequences and random frames vs a frame-level model.
module tb_spi_cmd_decoder;

    localparam int unsigned T      = 20;
    localparam logic [7:0]  SEED   = 8'h5A;
    localparam logic [27:0] RST_VEC = {8'h00, 8'hFF, 4'h0, 8'h00};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_cmd_decoder_if bus ();

    spi_cmd_decoder #(
        .TIMEOUT_CYC(T),
        .CHK_SEED   (SEED),
        .PERIOD_RST (8'hFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference: bytes of the frame in progress plus idle cycles since the last byte.
    logic [7:0] m_duty, m_period;
    logic       m_en, m_pol, m_upd, m_ferr;
    int         m_err;
    logic [7:0] fq[$];
    int         m_idle;

    typedef struct {
        logic [7:0] a, d, c;
        logic       upd, ferr;
        logic [7:0] duty, period;
        logic       en, pol;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [27:0] dut_vec();
        return {bus.duty, bus.period, bus.pwm_en, bus.pwm_pol, bus.update, bus.frame_err, bus.err_cnt};
    endfunction

    function automatic logic [27:0] model_vec();
        return {m_duty, m_period, m_en, m_pol, m_upd, m_ferr, 8'(m_err)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_duty = 8'h00; m_period = 8'hFF; m_en = 1'b0; m_pol = 1'b0;
        m_upd = 1'b0; m_ferr = 1'b0; m_err = 0;
        fq.delete();
        m_idle = 0;
    endtask

    task automatic model_reject();
        m_ferr = 1'b1;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step(input logic cs, input logic v, input logic [7:0] d);
        logic [7:0] a, x, c;
        m_upd  = 1'b0;
        m_ferr = 1'b0;
        if (v) begin
            fq.push_back(d);
            m_idle = 0;
            if (fq.size() == 3) begin
                a = fq[0]; x = fq[1]; c = fq[2];
                if (c == (a ^ x ^ SEED) && a < 8'd3) begin
                    m_upd = 1'b1;
                    if (a == 8'd0)      m_duty = x;
                    else if (a == 8'd1) m_period = x;
                    else begin
                        m_en  = x[0];
                        m_pol = x[1];
                    end
                end else begin
                    model_reject();
                end
                fq.delete();
            end
        end else if (fq.size() != 0) begin
            if (cs || m_idle == int'(T)) begin
                model_reject();
                fq.delete();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, check every output just after the edge.
    task automatic step(input logic cs, input logic v, input logic [7:0] d);
        bus.cs_n     = cs;
        bus.rx_valid = v;
        bus.rx_data  = d;
        model_step(cs, v, d);
        @(posedge clk);
        #1;
        chk("cycle_outputs", 64'(dut_vec()), 64'(model_vec()));
        chk("upd_err_exclusive", 64'(bus.update && bus.frame_err), 64'd0);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        step(1'b0, 1'b1, a);
        step(1'b0, 1'b1, d);
        step(1'b0, 1'b1, c);
    endtask

    initial begin
        int pulses;
        logic [7:0] ra, rd, rc;

        tbl[0] = '{a: 8'h00, d: 8'h80, c: 8'hDA, upd: 1'b1, ferr: 1'b0, duty: 8'h80, period: 8'hFF, en: 1'b0, pol: 1'b0, err: 8'd0};
        tbl[1] = '{a: 8'h02, d: 8'h03, c: 8'h5B, upd: 1'b1, ferr: 1'b0, duty: 8'h80, period: 8'hFF, en: 1'b1, pol: 1'b1, err: 8'd0};
        tbl[2] = '{a: 8'h01, d: 8'h64, c: 8'h3F, upd: 1'b1, ferr: 1'b0, duty: 8'h80, period: 8'h64, en: 1'b1, pol: 1'b1, err: 8'd0};
        tbl[3] = '{a: 8'h00, d: 8'h10, c: 8'h00, upd: 1'b0, ferr: 1'b1, duty: 8'h80, period: 8'h64, en: 1'b1, pol: 1'b1, err: 8'd1};
        tbl[4] = '{a: 8'h05, d: 8'h00, c: 8'h5F, upd: 1'b0, ferr: 1'b1, duty: 8'h80, period: 8'h64, en: 1'b1, pol: 1'b1, err: 8'd2};

        rst_n        = 1'b0;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        #12;
        chk("reset_values", 64'(dut_vec()), 64'(RST_VEC));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].a, tbl[i].d, tbl[i].c);
            chk($sformatf("table_frame_%0d", i),
                64'({bus.update, bus.frame_err, bus.duty, bus.period, bus.pwm_en, bus.pwm_pol, bus.err_cnt}),
                64'({tbl[i].upd, tbl[i].ferr, tbl[i].duty, tbl[i].period, tbl[i].en, tbl[i].pol, tbl[i].err}));
        end
        step(1'b0, 1'b0, 8'h00);

        // cs_n pulse after ADDR aborts; the next frame applies cleanly
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("cs_abort", 64'({bus.frame_err, bus.err_cnt}), 64'({1'b1, 8'd3}));
        step(1'b0, 1'b0, 8'h00);
        send_frame(8'h00, 8'h20, 8'h7A);
        chk("after_cs_abort_frame", 64'({bus.update, bus.duty, bus.err_cnt}), 64'({1'b1, 8'h20, 8'd3}));

        // Timeout in S_CHK, then the late byte starts a new frame
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h40);
        pulses = 0;
        repeat (T + 2) begin
            step(1'b0, 1'b0, 8'h00);
            pulses += int'(bus.frame_err);
        end
        chk("timeout_pulses", 64'(pulses), 64'd1);
        chk("timeout_err_cnt", 64'(bus.err_cnt), 64'd4);
        step(1'b0, 1'b1, 8'h1A);
        chk("late_byte_no_write", 64'({bus.update, bus.frame_err, bus.duty}), 64'({1'b0, 1'b0, 8'h20}));
        step(1'b1, 1'b0, 8'h00);
        chk("late_byte_is_addr", 64'({bus.frame_err, bus.err_cnt}), 64'({1'b1, 8'd5}));
        step(1'b0, 1'b0, 8'h00);

        // CHK byte arrives in the same cycle cs_n rises
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'h0F);
        chk("chk_with_cs_rise", 64'({bus.update, bus.frame_err, bus.duty}), 64'({1'b1, 1'b0, 8'h55}));
        step(1'b1, 1'b0, 8'h00);
        chk("cs_high_idle_no_err", 64'({bus.update, bus.frame_err, bus.err_cnt}), 64'({1'b0, 1'b0, 8'd5}));
        step(1'b0, 1'b0, 8'h00);

        // Random frames with gaps, timeouts, cs_n pulses and bad checksums/addresses
        for (int f = 0; f < 150; f++) begin
            ra = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) ra = 8'($urandom);
            rd = 8'($urandom);
            rc = ra ^ rd ^ SEED;
            if ($urandom_range(0, 3) == 0) rc = 8'($urandom);
            for (int b = 0; b < 3; b++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r == 0)      repeat (T + 1) step(1'b0, 1'b0, 8'h00);
                else if (r == 1) step(1'b1, 1'b0, 8'h00);
                else             repeat (r % 3) step(1'b0, 1'b0, 8'h00);
                step(1'($urandom_range(0, 9) == 0), 1'b1, (b == 0) ? ra : (b == 1) ? rd : rc);
            end
        end
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Reset in the middle of a frame
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h33);
        rst_n = 1'b0;
        #1;
        chk("async_reset_values", 64'(dut_vec()), 64'(RST_VEC));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("reset_no_err", 64'({bus.frame_err, bus.err_cnt}), 64'd0);
        send_frame(8'h02, 8'h01, 8'h59);
        chk("after_reset_ctrl", 64'({bus.update, bus.pwm_en, bus.pwm_pol, bus.err_cnt}), 64'({1'b1, 1'b1, 1'b0, 8'd0}));

        // err_cnt saturates
        repeat (300) send_frame(8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("err_cnt_saturated", 64'(bus.err_cnt), 64'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Frame parser that sits directly downstream of the SPI byte receiver: consumes its byte stream (`data` / `data_received`) plus the chip-select line, assembles 3-byte command frames, verifies a checksum and updates the PWM control registers that feed the PWM generator. Malformed, aborted or stalled frames are discarded and counted, never applied.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1000: maximum allowed `clk` cycles between bytes of one frame. This is 1 ms at 1 MHz.
- `CHK_SEED`, default 8'h5A: seed XORed into the frame checksum.
- `PERIOD_RST`, default 8'hFF: reset value of `period`.

Ports:
- `clk`  in  1: sampling clock, the same clock as the SPI receiver.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_n`  in  1: SPI chip select, active low. Must already be synchronised to `clk`.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid while it is high.
- `duty`  out  8: PWM duty register.
- `period`  out  8: PWM period register.
- `pwm_en`  out  1: PWM enable.
- `pwm_pol`  out  1: output polarity; 1 means inverted.
- `update`  out  1: one-cycle pulse when any register is written.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected.
- `err_cnt`  out  8: saturating count of rejected frames.

## Operation
- Frame layout: ADDR, DATA, CHK, where CHK = ADDR ^ DATA ^ `CHK_SEED`.
- Register map:
  - 0x00: `duty`.
  - 0x01: `period`.
  - 0x02: `pwm_en` = DATA[0], `pwm_pol` = DATA[1]. DATA[7:2] are ignored.
  - Any other address: rejected at CHK time.
- FSM states are S_ADDR (the reset state), S_DATA and S_CHK.
  - S_ADDR: on `rx_valid`, latch the address and go to S_DATA.
  - S_DATA: on `rx_valid`, latch the data and go to S_CHK.
  - S_CHK: on `rx_valid`, compare the byte with the computed checksum. If it matches and the address is 0x00–0x02, write the register and pulse `update`. Otherwise pulse `frame_err` and increment `err_cnt`. Return to S_ADDR in both cases.
- Abort, in S_DATA or S_CHK only:
  - Trigger 1: `cs_n` is high with no `rx_valid` in the same cycle.
  - Trigger 2: the inter-byte timer reaches `TIMEOUT_CYC`.
  - Action: return to S_ADDR, pulse `frame_err`, increment `err_cnt`.
- In S_ADDR, `cs_n` high and timer expiry do nothing.
- Simultaneous events: `rx_valid` together with `cs_n` high in the same cycle means the byte is processed normally, and only then does an abort apply. If that byte completes the frame, the frame is applied.
- Inter-byte timer:
  - Cleared on every `rx_valid` and whenever the FSM is in S_ADDR.
  - Counts up otherwise and saturates at `TIMEOUT_CYC`.
  - Width is $clog2(TIMEOUT_CYC+1).
- `err_cnt` saturates at 8'hFF and never wraps.
- Back-to-back frames are supported with no idle cycle needed. `rx_valid` can arrive on consecutive cycles.

## Timing
- Reset values: `duty` = 0, `period` = `PERIOD_RST`, `pwm_en` = 0, `pwm_pol` = 0, `update` = 0, `frame_err` = 0, `err_cnt` = 0. FSM is in S_ADDR and the timer is 0.
- Register write and `update` both become visible on the `clk` edge after the cycle in which the CHK byte's `rx_valid` is high. Latency is 1 cycle.
- `frame_err` follows the same 1-cycle latency from the CHK byte or from the abort condition.
- Timeout fires when the timer holds `TIMEOUT_CYC`. The abort is registered on the next edge.
- `update` and `frame_err` are never high in the same cycle.
- Asserting `rst_n` mid-frame:
  - The partial frame is dropped and all outputs return to their reset values immediately.
  - No `frame_err` pulse is generated and no count is taken.

## Structure
- Shared package `pwm_pkg`:
  - Register address constants `ADDR_DUTY`, `ADDR_PERIOD`, `ADDR_CTRL`.
  - The FSM state enum.
  - Control bit positions `CTRL_EN` = 0, `CTRL_POL` = 1.
  - The default `CHK_SEED`.
- Single natural sub-module: `frame_timer`, the inter-byte timeout counter with clear and expired outputs.
- The register bank stays inline.

## Test plan
- Frame 00, 80, DA -> `duty` = 8'h80, one `update` pulse one cycle after the CHK byte, `err_cnt` = 0.
- Frame 02, 03, 5B -> `pwm_en` = 1, `pwm_pol` = 1. A second frame 01, 64, 3F -> `period` = 8'h64.
- Frame 00, 10, 00 (bad checksum) -> `duty` unchanged, one `frame_err` pulse, `err_cnt` = 1. Frame 05, 00, 5F (bad address) -> `err_cnt` = 2.
- Send ADDR 00, then raise `cs_n` for 1 cycle -> `frame_err`. The next frame 00, 20, 7A applies `duty` = 8'h20.
- Send 00, 40, wait `TIMEOUT_CYC`+2 cycles, send 1A -> abort error. The 1A byte is taken as a new ADDR, so no write occurs.
- CHK byte `rx_valid` coincident with `cs_n` rising -> frame applied with no error. Separately, 300 bad frames -> `err_cnt` holds at 8'hFF. Separately, `rst_n` low mid-frame -> all reset values restored and no error pulse.
